// File: rtl/exec_stage_mc_pkg.sv
// Shared encodings for the exec_stage_mc execute stage: ALU opcodes, forwarding selects
// and the multiplier FSM state type.
package exec_pkg;

    // ALU_MULT/ALU_MULTU with reg_write set act as MUL: LO is written back to the destination.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_NOR   = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_SLTU  = 4'd7,
        ALU_SLL   = 4'd8,
        ALU_SRL   = 4'd9,
        ALU_SRA   = 4'd10,
        ALU_LUI   = 4'd11,
        ALU_MFHI  = 4'd12,
        ALU_MFLO  = 4'd13,
        ALU_MULT  = 4'd14,
        ALU_MULTU = 4'd15
    } alu_op_e;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_REG  = 2'd0;
    localparam fwd_sel_t FWD_MEM  = 2'd1;
    localparam fwd_sel_t FWD_WB   = 2'd2;
    localparam fwd_sel_t FWD_RSVD = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_e;

    function automatic logic is_mul_op(input alu_op_e op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

endpackage

// File: rtl/exec_stage_mc_iter_multiplier.sv
// Iterative shift-add multiplier: retires DATA_W/MUL_CYCLES multiplier bits per cycle on
// operand magnitudes and applies the sign at completion.
module iter_multiplier
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);
    localparam int unsigned STEP_W = DATA_W / MUL_CYCLES;
    localparam int unsigned CNT_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    mul_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic                neg_q, neg_d;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [PROD_W-1:0]   acc_next;

    always_comb begin
        a_mag    = (signed_i && a_i[DATA_W-1]) ? -a_i : a_i;
        b_mag    = (signed_i && b_i[DATA_W-1]) ? -b_i : b_i;
        acc_next = acc_q + mcand_q * PROD_W'(mplier_q[STEP_W-1:0]);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        done_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = PROD_W'(a_mag);
                    mplier_d = b_mag;
                    neg_d    = signed_i & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
                end
            end
            BUSY: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << STEP_W;
                    mplier_d = mplier_q >> STEP_W;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        done_o  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
        end
    end

    assign busy_o    = (state_q == BUSY);
    assign product_o = neg_q ? -acc_next : acc_next;

endmodule

// File: rtl/exec_stage_mc.sv
// Registered MIPS execute stage: forwarding, ALU, iterative multiplier with HI/LO and stall.
// Define EXEC_OVF_TRAP_EN to trap signed ADD/SUB overflow (suppresses write-back).
module exec_stage_mc
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic [4:0]        shamt,
    input  logic              alusrc,
    input  logic              regdst,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rt,
    input  logic              reg_write_in,
    input  logic [1:0]        fwd_a_sel,
    input  logic [1:0]        fwd_b_sel,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic [DATA_W-1:0] wb_fwd_data,
    output logic              stall_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_reg_write,
    output logic              out_zero,
    output logic              ovf_trap
);
    localparam int unsigned MSB = DATA_W - 1;

    alu_op_e             op;
    logic [DATA_W-1:0]   op_a, rt_fwd, op_b, alu_res;
    logic [REG_AW-1:0]   dest;
    logic                ovf, accept, mul_start, mul_busy, mul_done;
    logic [2*DATA_W-1:0] mul_prod;

    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic [REG_AW-1:0]   dest_q, dest_d, mul_dest_q, mul_dest_d;
    logic                valid_q, valid_d, wr_q, wr_d, zero_q, zero_d;
    logic                ovf_q, ovf_d, mul_wb_q, mul_wb_d;

    assign op        = alu_op_e'(alu_op);
    assign dest      = regdst ? rd : rt;
    assign accept    = in_valid & ~flush & ~mul_busy;
    assign mul_start = accept & is_mul_op(op);

    // The reserved select falls back to the register-file operand.
    always_comb begin
        case (fwd_sel_t'(fwd_a_sel))
            FWD_MEM: op_a = mem_fwd_data;
            FWD_WB:  op_a = wb_fwd_data;
            default: op_a = rs_data;
        endcase
        case (fwd_sel_t'(fwd_b_sel))
            FWD_MEM: rt_fwd = mem_fwd_data;
            FWD_WB:  rt_fwd = wb_fwd_data;
            default: rt_fwd = rt_data;
        endcase
        op_b = alusrc ? imm : rt_fwd;
    end

    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLT:  alu_res = DATA_W'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res = DATA_W'(op_a < op_b);
            ALU_SLL:  alu_res = op_b << shamt;
            ALU_SRL:  alu_res = op_b >> shamt;
            ALU_SRA:  alu_res = $signed(op_b) >>> shamt;
            ALU_LUI:  alu_res = op_b << (DATA_W / 2);
            ALU_MFHI: alu_res = hi_q;
            ALU_MFLO: alu_res = lo_q;
            default:  alu_res = '0;
        endcase
    end

`ifdef EXEC_OVF_TRAP_EN
    always_comb begin
        case (op)
            ALU_ADD: ovf = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            ALU_SUB: ovf = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            default: ovf = 1'b0;
        endcase
    end
`else
    assign ovf = 1'b0;
`endif

    iter_multiplier #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk_i     (Clk),
        .rst_ni    (Reset),
        .start_i   (mul_start),
        .abort_i   (flush),
        .signed_i  (op == ALU_MULT),
        .a_i       (op_a),
        .b_i       (op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // Completion wins over new input; the multiplier masks done when flush aborts it.
    always_comb begin
        valid_d    = 1'b0;
        wr_d       = 1'b0;
        ovf_d      = 1'b0;
        result_d   = result_q;
        dest_d     = dest_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mul_dest_d = mul_dest_q;
        mul_wb_d   = mul_wb_q;
        if (mul_done) begin
            {hi_d, lo_d} = mul_prod;
            if (mul_wb_q) begin
                valid_d  = 1'b1;
                wr_d     = 1'b1;
                result_d = mul_prod[DATA_W-1:0];
                dest_d   = mul_dest_q;
            end
        end else if (mul_start) begin
            mul_dest_d = dest;
            mul_wb_d   = reg_write_in;
        end else if (accept) begin
            valid_d  = 1'b1;
            result_d = alu_res;
            dest_d   = dest;
            wr_d     = reg_write_in & ~ovf;
            ovf_d    = ovf;
        end
        zero_d = (result_d == '0);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            result_q   <= '0;
            dest_q     <= '0;
            mul_dest_q <= '0;
            valid_q    <= 1'b0;
            wr_q       <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            mul_wb_q   <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            result_q   <= result_d;
            dest_q     <= dest_d;
            mul_dest_q <= mul_dest_d;
            valid_q    <= valid_d;
            wr_q       <= wr_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            mul_wb_q   <= mul_wb_d;
        end
    end

    assign stall_out     = mul_busy;
    assign out_valid     = valid_q;
    assign out_result    = result_q;
    assign out_dest      = dest_q;
    assign out_reg_write = wr_q;
    assign out_zero      = zero_q;
    assign ovf_trap      = ovf_q;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed self-checking bench for exec_stage_mc (default DATA_W=32, MUL_CYCLES=4).
`timescale 1ns/1ps
module tb_exec_stage_mc;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,   OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_NOR = 4'd5,  OP_SLT = 4'd6,   OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8,  OP_SRL = 4'd9,  OP_SRA = 4'd10,  OP_LUI = 4'd11;
    localparam logic [3:0] OP_MFHI = 4'd12, OP_MFLO = 4'd13, OP_MULT = 4'd14, OP_MULTU = 4'd15;

    logic        Clk = 1'b0, Reset = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [31:0] rs_data = '0, rt_data = '0, imm = '0, mem_fwd_data = '0, wb_fwd_data = '0;
    logic [4:0]  shamt = '0, rd = '0, rt = '0;
    logic        alusrc = 1'b0, regdst = 1'b0, reg_write_in = 1'b0;
    logic [1:0]  fwd_a_sel = '0, fwd_b_sel = '0;
    logic        stall_out, out_valid, out_reg_write, out_zero, ovf_trap;
    logic [31:0] out_result;
    logic [4:0]  out_dest;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;
    vec_t alu_vec [11];

    exec_stage_mc dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .flush(flush), .alu_op(alu_op),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .shamt(shamt), .alusrc(alusrc),
        .regdst(regdst), .rd(rd), .rt(rt), .reg_write_in(reg_write_in),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_data(wb_fwd_data), .stall_out(stall_out), .out_valid(out_valid),
        .out_result(out_result), .out_dest(out_dest), .out_reg_write(out_reg_write),
        .out_zero(out_zero), .ovf_trap(ovf_trap)
    );

    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dst, input logic wr);
        alu_op = op; rs_data = a; rt_data = b; imm = '0; shamt = '0;
        alusrc = 1'b0; regdst = 1'b1; rd = dst; rt = 5'd31; reg_write_in = wr;
        fwd_a_sel = 2'd0; fwd_b_sel = 2'd0; in_valid = 1'b1; flush = 1'b0;
    endtask

    // Cycles while stall_out is high (bounded); reports count and whether a bubble leaked.
    task automatic wait_mul(output int n, output logic leaked);
        n = 0;
        leaked = 1'b0;
        while (stall_out && n < 20) begin
            if (out_valid) leaked = 1'b1;
            n++;
            cyc();
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({stall_out, out_valid, out_reg_write, out_zero, ovf_trap, out_dest, out_result} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b valid=%b wr=%b zero=%b ovf=%b dest=%0d res=%h, expected all 0",
                     stall_out, out_valid, out_reg_write, out_zero, ovf_trap, out_dest, out_result);
        end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_add_ovf();
        logic [1:0] exp_wr_ovf;
`ifdef EXEC_OVF_TRAP_EN
        exp_wr_ovf = 2'b01;
`else
        exp_wr_ovf = 2'b10;
`endif
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1);
        cyc();
        checks++;
        if ({out_valid, out_zero, out_dest, out_result} !== {1'b1, 1'b0, 5'd3, 32'h8000_0000}) begin
            errors++;
            $display("FAIL add_wrap: got valid=%b zero=%b dest=%0d res=%h, expected 1 0 3 80000000",
                     out_valid, out_zero, out_dest, out_result);
        end
        checks++;
        if ({out_reg_write, ovf_trap} !== exp_wr_ovf) begin
            errors++;
            $display("FAIL add_ovf_flags: got wr/ovf=%b, expected %b", {out_reg_write, ovf_trap}, exp_wr_ovf);
        end
        issue(OP_ADD, 32'd2, 32'd3, 5'd4, 1'b1);
        cyc();
        checks++;
        if ({out_result, out_reg_write, ovf_trap} !== {32'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_plain: got res=%h wr=%b ovf=%b, expected 00000005 1 0",
                     out_result, out_reg_write, ovf_trap);
        end
    endtask

    task automatic test_alu();
        alu_vec[0]  = '{OP_SUB,  32'd9,          32'd9,          5'd0,  32'h0000_0000};
        alu_vec[1]  = '{OP_AND,  32'hF0F0_1234,  32'h0FF0_FFFF,  5'd0,  32'h00F0_1234};
        alu_vec[2]  = '{OP_OR,   32'hF000_0000,  32'h0000_000F,  5'd0,  32'hF000_000F};
        alu_vec[3]  = '{OP_XOR,  32'hFFFF_0000,  32'h0F0F_0F0F,  5'd0,  32'hF0F0_0F0F};
        alu_vec[4]  = '{OP_NOR,  32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF};
        alu_vec[5]  = '{OP_SLT,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1};
        alu_vec[6]  = '{OP_SLTU, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0};
        alu_vec[7]  = '{OP_SLL,  32'd0,          32'd1,          5'd31, 32'h8000_0000};
        alu_vec[8]  = '{OP_SRL,  32'd0,          32'h8000_0000,  5'd4,  32'h0800_0000};
        alu_vec[9]  = '{OP_SRA,  32'd0,          32'h8000_0000,  5'd4,  32'hF800_0000};
        alu_vec[10] = '{OP_LUI,  32'd0,          32'h0000_1234,  5'd0,  32'h1234_0000};
        for (int i = 0; i < 11; i++) begin
            issue(alu_vec[i].op, alu_vec[i].a, alu_vec[i].b, 5'd2, 1'b1);
            shamt = alu_vec[i].sh;
            cyc();
            checks++;
            if ({out_valid, out_zero, out_result} !== {1'b1, alu_vec[i].exp == 32'd0, alu_vec[i].exp}) begin
                errors++;
                $display("FAIL alu_vec%0d: got valid=%b zero=%b res=%h, expected res=%h",
                         i, out_valid, out_zero, out_result, alu_vec[i].exp);
            end
        end
        issue(OP_ADD, 32'd100, 32'd5, 5'd2, 1'b1);
        imm = 32'hFFFF_FFFF; alusrc = 1'b1; regdst = 1'b0; rt = 5'd7;
        cyc();
        checks++;
        if ({out_result, out_dest} !== {32'd99, 5'd7}) begin
            errors++;
            $display("FAIL alusrc_regdst: got res=%h dest=%0d, expected 00000063 7", out_result, out_dest);
        end
    endtask

    task automatic test_forwarding();
        issue(OP_SUB, 32'd100, 32'd50, 5'd1, 1'b1);
        fwd_a_sel = 2'd1; mem_fwd_data = 32'd5; fwd_b_sel = 2'd2; wb_fwd_data = 32'd3;
        cyc();
        checks++;
        if (out_result !== 32'd2) begin
            errors++;
            $display("FAIL fwd_mem_wb: got %h, expected 00000002", out_result);
        end
        issue(OP_SUB, 32'd10, 32'd4, 5'd1, 1'b1);
        fwd_a_sel = 2'd3; fwd_b_sel = 2'd3;
        cyc();
        checks++;
        if (out_result !== 32'd6) begin
            errors++;
            $display("FAIL fwd_reserved: got %h, expected 00000006", out_result);
        end
        issue(OP_ADD, 32'd10, 32'd77, 5'd1, 1'b1);
        fwd_b_sel = 2'd1; mem_fwd_data = 32'd1000; imm = 32'd8; alusrc = 1'b1;
        cyc();
        checks++;
        if (out_result !== 32'd18) begin
            errors++;
            $display("FAIL fwd_b_vs_imm: got %h, expected 00000012", out_result);
        end
    endtask

    task automatic test_idle_flush();
        idle();
        cyc();
        checks++;
        if ({out_valid, out_reg_write, out_result} !== {2'b00, 32'd18}) begin
            errors++;
            $display("FAIL idle_hold: got valid=%b wr=%b res=%h, expected 0 0 00000012",
                     out_valid, out_reg_write, out_result);
        end
        issue(OP_ADD, 32'd1, 32'd1, 5'd6, 1'b1);
        flush = 1'b1;
        cyc();
        checks++;
        if ({out_valid, out_reg_write, out_result} !== {2'b00, 32'd18}) begin
            errors++;
            $display("FAIL idle_flush: got valid=%b wr=%b res=%h, expected 0 0 00000012",
                     out_valid, out_reg_write, out_result);
        end
        idle();
    endtask

    task automatic test_mult();
        int n;
        logic leaked;
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b0);
        cyc();
        issue(OP_MFLO, 32'd0, 32'd0, 5'd4, 1'b1);
        wait_mul(n, leaked);
        checks++;
        if (n != 4 || leaked !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mult_stall: got stall_cycles=%0d bubble_leak=%b valid_at_done=%b, expected 4 0 0",
                     n, leaked, out_valid);
        end
        cyc();
        checks++;
        if ({out_valid, out_dest, out_result} !== {1'b1, 5'd4, 32'hFFFF_FFFE}) begin
            errors++;
            $display("FAIL mult_mflo: got valid=%b dest=%0d res=%h, expected 1 4 fffffffe",
                     out_valid, out_dest, out_result);
        end
        issue(OP_MFHI, 32'd0, 32'd0, 5'd4, 1'b1);
        cyc();
        checks++;
        if (out_result !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mult_mfhi: got %h, expected ffffffff", out_result);
        end
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 5'd0, 1'b0);
        cyc();
        issue(OP_MFLO, 32'd0, 32'd0, 5'd4, 1'b1);
        wait_mul(n, leaked);
        cyc();
        checks++;
        if (out_result !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL mult_neg_lo: got %h, expected fffffff1", out_result);
        end
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b0);
        cyc();
        issue(OP_MFHI, 32'd0, 32'd0, 5'd4, 1'b1);
        wait_mul(n, leaked);
        cyc();
        checks++;
        if (out_result !== 32'd1) begin
            errors++;
            $display("FAIL multu_hi: got %h, expected 00000001", out_result);
        end
        idle();
    endtask

    task automatic test_mul();
        int n;
        logic leaked;
        issue(OP_MULT, 32'd6, 32'd7, 5'd9, 1'b1);
        cyc();
        idle();
        wait_mul(n, leaked);
        checks++;
        if (n != 4 || leaked !== 1'b0) begin
            errors++;
            $display("FAIL mul_bubbles: got stall_cycles=%0d bubble_leak=%b, expected 4 0", n, leaked);
        end
        checks++;
        if ({out_valid, out_reg_write, out_dest, out_result} !== {2'b11, 5'd9, 32'd42}) begin
            errors++;
            $display("FAIL mul_result: got valid=%b wr=%b dest=%0d res=%h, expected 1 1 9 0000002a",
                     out_valid, out_reg_write, out_dest, out_result);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_single_valid: got valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_flush_busy();
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
        cyc();
        idle();
        cyc();
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++;
        if ({stall_out, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL flush_cnt2: got stall=%b valid=%b, expected 0 0", stall_out, out_valid);
        end
        issue(OP_MFLO, 32'd0, 32'd0, 5'd4, 1'b1);
        cyc();
        issue(OP_MFHI, 32'd0, 32'd0, 5'd4, 1'b1);
        checks++;
        if (out_result !== 32'd42) begin
            errors++;
            $display("FAIL flush_lo_kept: got %h, expected 0000002a", out_result);
        end
        cyc();
        checks++;
        if (out_result !== 32'd0) begin
            errors++;
            $display("FAIL flush_hi_kept: got %h, expected 00000000", out_result);
        end
        issue(OP_MULT, 32'd3, 32'd3, 5'd0, 1'b0);
        cyc();
        idle();
        cyc();
        cyc();
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        issue(OP_MFLO, 32'd0, 32'd0, 5'd4, 1'b1);
        cyc();
        checks++;
        if (out_result !== 32'd42) begin
            errors++;
            $display("FAIL flush_beats_done: got %h, expected 0000002a", out_result);
        end
        idle();
    endtask

    task automatic test_reset_busy();
        issue(OP_MULT, 32'd5, 32'd5, 5'd9, 1'b1);
        cyc();
        idle();
        cyc();
        cyc();
        Reset = 1'b0;
        #1;
        checks++;
        if ({stall_out, out_valid, out_reg_write, out_zero, ovf_trap, out_dest, out_result} !== '0) begin
            errors++;
            $display("FAIL reset_mid_busy: got stall=%b valid=%b wr=%b dest=%0d res=%h, expected all 0",
                     stall_out, out_valid, out_reg_write, out_dest, out_result);
        end
        @(negedge Clk);
        Reset = 1'b1;
        issue(OP_MFLO, 32'd0, 32'd0, 5'd4, 1'b1);
        cyc();
        issue(OP_MFHI, 32'd0, 32'd0, 5'd4, 1'b1);
        checks++;
        if ({out_valid, out_result} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL reset_lo_cleared: got valid=%b res=%h, expected 1 00000000", out_valid, out_result);
        end
        cyc();
        checks++;
        if ({stall_out, out_result} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_hi_cleared: got stall=%b res=%h, expected 0 00000000", stall_out, out_result);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_alu();
        test_forwarding();
        test_idle_flush();
        test_mult();
        test_mul();
        test_flush_busy();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
